mc_control_fsm: RTL and testbench

- Main control unit for the multicycle MIPS datapath. It sits directly upstream of the unified instruction/data memory and drives its write enable and address-select mux (IorD).
- Moore state machine sequences fetch/decode/execute/memory/writeback for lw, sw, R-type, beq, addi and j.
- Contains an ALU decoder that maps aluop and funct to the ALU control code.
- Supports a configurable memory-read wait so slower memories can replace the async-read array.

---
 rtl/mc_pkg.sv | 43 ++++
 rtl/alu_decoder.sv | 28 ++
 rtl/mc_control_fsm.sv | 154 +++++++++++++++
 tb/tb_mc_control_fsm.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multicycle MIPS control unit
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMRD    = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWR    = 4'd6,
    S_EXECUTE  = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_ADDIEXEC = 4'd10,
    S_ADDIWB   = 4'd11,
    S_JUMP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps aluop and funct to the 3-bit ALU control code
module alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctl
);

  always_comb begin
    alu_ctl = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alu_ctl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_ctl = ALU_ADD;
          FN_SUB:  alu_ctl = ALU_SUB;
          FN_AND:  alu_ctl = ALU_AND;
          FN_OR:   alu_ctl = ALU_OR;
          FN_SLT:  alu_ctl = ALU_SLT;
          default: alu_ctl = ALU_ADD;
        endcase
      end
      default: alu_ctl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - Moore control FSM for the multicycle MIPS datapath
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int MEM_LAT = 0,
  parameter int OP_W    = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] op,
  input  logic [OP_W-1:0] funct,
  input  logic            zero,
  output logic            iord,
  output logic            mem_we,
  output logic            ir_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      pc_src,
  output logic            pc_en,
  output logic [2:0]      alu_ctl,
  output logic            illegal_op,
  output logic [3:0]      state
);

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  state_t     cur, nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       wait_done;
  logic       pc_write, branch;
  logic [1:0] aluop;

  assign wait_done = (cnt == LAT);
  assign state     = cur;
  assign pc_en     = pc_write | (branch & zero);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= S_IDLE;
      cnt <= 3'd0;
    end else begin
      cur <= nxt;
      cnt <= cnt_nxt;
    end
  end

  // FETCH and MEMRD stall until the wait counter reaches MEM_LAT
  always_comb begin
    nxt     = cur;
    cnt_nxt = 3'd0;
    case (cur)
      S_IDLE:  nxt = S_FETCH;
      S_FETCH: begin
        if (wait_done) nxt = S_DECODE;
        else           cnt_nxt = cnt + 3'd1;
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE:     nxt = S_EXECUTE;
          OP_BEQ:       nxt = S_BRANCH;
          OP_ADDI:      nxt = S_ADDIEXEC;
          OP_J:         nxt = S_JUMP;
          default:      nxt = S_FETCH;
        endcase
      end
      S_MEMADR: nxt = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (wait_done) nxt = S_MEMWB;
        else           cnt_nxt = cnt + 3'd1;
      end
      S_EXECUTE:  nxt = S_ALUWB;
      S_ADDIEXEC: nxt = S_ADDIWB;
      default:    nxt = S_FETCH;
    endcase
  end

  always_comb begin
    iord       = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    pc_write   = 1'b0;
    branch     = 1'b0;
    aluop      = ALUOP_ADD;
    illegal_op = 1'b0;
    case (cur)
      S_FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = wait_done;
        pc_write  = wait_done;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
          default: illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        iord   = 1'b1;
        mem_we = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_SUB;
        pc_src    = 2'b01;
        branch    = 1'b1;
      end
      S_ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop   (aluop),
    .funct   (funct),
    .alu_ctl (alu_ctl)
  );

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - directed checks of the multicycle control FSM
module tb_mc_control_fsm;

  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] op, funct;
  logic zero;
  int checks = 0;
  int failures = 0;

  logic iord, mem_we, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, pc_en, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctl;
  logic [3:0] state;

  logic iord_2, mem_we_2, ir_write_2, reg_dst_2, mem_to_reg_2, reg_write_2, alu_src_a_2, pc_en_2, illegal_op_2;
  logic [1:0] alu_src_b_2, pc_src_2;
  logic [2:0] alu_ctl_2;
  logic [3:0] state_2;

  always #5 clk = ~clk;

  mc_control_fsm #(.MEM_LAT(0)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .iord(iord), .mem_we(mem_we), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .pc_en(pc_en), .alu_ctl(alu_ctl),
    .illegal_op(illegal_op), .state(state)
  );

  mc_control_fsm #(.MEM_LAT(2)) dut_lat2 (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .iord(iord_2), .mem_we(mem_we_2), .ir_write(ir_write_2), .reg_dst(reg_dst_2),
    .mem_to_reg(mem_to_reg_2), .reg_write(reg_write_2), .alu_src_a(alu_src_a_2),
    .alu_src_b(alu_src_b_2), .pc_src(pc_src_2), .pc_en(pc_en_2), .alu_ctl(alu_ctl_2),
    .illegal_op(illegal_op_2), .state(state_2)
  );

  task step;
    @(posedge clk);
    #1;
  endtask

  // leaves both DUTs in the first FETCH cycle
  task reset_to_fetch;
    rst_n = 1'b0;
    step;
    #1 rst_n = 1'b1;
    step;
  endtask

  task test_reset;
    logic [14:0] outs;
    zero = 1'b1;
    op = 6'b100011;
    funct = 6'b0;
    rst_n = 1'b0;
    repeat (3) begin
      step;
      outs = {iord, mem_we, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
              alu_src_b, pc_src, pc_en, illegal_op, 2'b00};
      checks++;
      if (state !== 4'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
      checks++;
      if (outs !== 15'd0) begin failures++; $display("FAIL reset_outputs got=%0h exp=0", outs); end
    end
    #1 rst_n = 1'b1;
    step;
    checks++;
    if (state !== 4'd1) begin failures++; $display("FAIL reset_release_state got=%0d exp=1", state); end
    checks++;
    if ({ir_write, pc_en, alu_src_b} !== 4'b1101)
      begin failures++; $display("FAIL first_fetch got=%b exp=1101", {ir_write, pc_en, alu_src_b}); end
    zero = 1'b0;
  endtask

  task test_lw;
    logic [3:0] seq [6];
    seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1};
    op = 6'b100011;
    reset_to_fetch;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (state !== seq[i]) begin failures++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, state, seq[i]); end
      checks++;
      if (iord !== (seq[i] == 4'd4)) begin failures++; $display("FAIL lw_iord[%0d] got=%b", i, iord); end
      checks++;
      if ({mem_to_reg, reg_write} !== {2{seq[i] == 4'd5}})
        begin failures++; $display("FAIL lw_wb[%0d] got=%b", i, {mem_to_reg, reg_write}); end
      checks++;
      if (mem_we !== 1'b0) begin failures++; $display("FAIL lw_mem_we[%0d] got=%b exp=0", i, mem_we); end
      if (i < 5) step;
    end
  endtask

  // continues directly from the FETCH that follows test_lw, no reset
  task test_back_to_back;
    logic [3:0] seq [5];
    int we_cycles;
    seq = '{4'd1, 4'd2, 4'd3, 4'd6, 4'd1};
    we_cycles = 0;
    op = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (state !== seq[i]) begin failures++; $display("FAIL sw_state[%0d] got=%0d exp=%0d", i, state, seq[i]); end
      if (mem_we === 1'b1) begin
        we_cycles++;
        checks++;
        if (iord !== 1'b1) begin failures++; $display("FAIL sw_iord got=%b exp=1", iord); end
      end
      if (i < 4) step;
    end
    checks++;
    if (we_cycles != 1) begin failures++; $display("FAIL sw_we_cycles got=%0d exp=1", we_cycles); end
  endtask

  task test_rtype;
    op = 6'b000000;
    funct = 6'b101010;
    reset_to_fetch;
    step;
    step;
    checks++;
    if ({state, alu_ctl, alu_src_a} !== {4'd7, 3'b111, 1'b1})
      begin failures++; $display("FAIL rtype_exec got=%0d/%b/%b exp=7/111/1", state, alu_ctl, alu_src_a); end
    step;
    checks++;
    if ({state, reg_dst, reg_write} !== {4'd8, 2'b11})
      begin failures++; $display("FAIL rtype_aluwb got=%0d/%b exp=8/11", state, {reg_dst, reg_write}); end
    step;
    checks++;
    if (state !== 4'd1) begin failures++; $display("FAIL rtype_return got=%0d exp=1", state); end
  endtask

  task test_alu_decode;
    logic [5:0] fn [6];
    logic [2:0] ex [6];
    fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
    ex = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
    op = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      funct = fn[i];
      reset_to_fetch;
      step;
      checks++;
      if (alu_ctl !== 3'b010) begin failures++; $display("FAIL decode_aluctl[%0d] got=%b exp=010", i, alu_ctl); end
      step;
      checks++;
      if (alu_ctl !== ex[i]) begin failures++; $display("FAIL funct_aluctl[%0d] got=%b exp=%b", i, alu_ctl, ex[i]); end
    end
  endtask

  task test_beq_j;
    op = 6'b000100;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      reset_to_fetch;
      step;
      step;
      checks++;
      if ({state, pc_src, alu_ctl} !== {4'd9, 2'b01, 3'b110})
        begin failures++; $display("FAIL beq_state got=%0d/%b/%b exp=9/01/110", state, pc_src, alu_ctl); end
      checks++;
      if (pc_en !== z[0]) begin failures++; $display("FAIL beq_pc_en zero=%0d got=%b exp=%b", z, pc_en, z[0]); end
      step;
      checks++;
      if (state !== 4'd1) begin failures++; $display("FAIL beq_return got=%0d exp=1", state); end
    end
    zero = 1'b0;
    op = 6'b000010;
    reset_to_fetch;
    step;
    step;
    checks++;
    if ({state, pc_src, pc_en} !== {4'd12, 2'b10, 1'b1})
      begin failures++; $display("FAIL jump got=%0d/%b/%b exp=12/10/1", state, pc_src, pc_en); end
    step;
    checks++;
    if (state !== 4'd1) begin failures++; $display("FAIL jump_return got=%0d exp=1", state); end
  endtask

  task test_addi;
    op = 6'b001000;
    reset_to_fetch;
    step;
    step;
    checks++;
    if ({state, alu_src_a, alu_src_b, alu_ctl} !== {4'd10, 1'b1, 2'b10, 3'b010})
      begin failures++; $display("FAIL addi_exec got=%0d/%b/%b/%b", state, alu_src_a, alu_src_b, alu_ctl); end
    step;
    checks++;
    if ({state, reg_write, reg_dst, mem_to_reg} !== {4'd11, 3'b100})
      begin failures++; $display("FAIL addi_wb got=%0d/%b exp=11/100", state, {reg_write, reg_dst, mem_to_reg}); end
  endtask

  task test_illegal;
    op = 6'b111111;
    reset_to_fetch;
    checks++;
    if (illegal_op !== 1'b0) begin failures++; $display("FAIL illegal_in_fetch got=%b exp=0", illegal_op); end
    step;
    checks++;
    if ({state, illegal_op} !== {4'd2, 1'b1})
      begin failures++; $display("FAIL illegal_decode got=%0d/%b exp=2/1", state, illegal_op); end
    step;
    checks++;
    if ({state, illegal_op, reg_write, mem_we} !== {4'd1, 3'b000})
      begin failures++; $display("FAIL illegal_refetch got=%0d/%b exp=1/000", state, {illegal_op, reg_write, mem_we}); end
  endtask

  task test_mem_lat2;
    logic [3:0] seq [10];
    int irw;
    seq = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd5, 4'd1};
    irw = 0;
    op = 6'b100011;
    reset_to_fetch;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (state_2 !== seq[i]) begin failures++; $display("FAIL lat2_state[%0d] got=%0d exp=%0d", i, state_2, seq[i]); end
      if (ir_write_2 === 1'b1) begin
        irw++;
        checks++;
        if (i != 2) begin failures++; $display("FAIL lat2_irw_cycle got=%0d exp=2", i); end
      end
      if (i < 9) step;
    end
    checks++;
    if (irw != 1) begin failures++; $display("FAIL lat2_irw_count got=%0d exp=1", irw); end
  endtask

  task test_reset_in_memrd;
    logic saw_rw;
    saw_rw = 1'b0;
    op = 6'b100011;
    reset_to_fetch;
    step;
    step;
    step;
    checks++;
    if (state !== 4'd4) begin failures++; $display("FAIL pre_reset_memrd got=%0d exp=4", state); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({state, state_2} !== 8'd0) begin failures++; $display("FAIL async_reset got=%0d/%0d exp=0/0", state, state_2); end
    repeat (3) begin
      step;
      if (reg_write === 1'b1) saw_rw = 1'b1;
    end
    checks++;
    if (saw_rw !== 1'b0) begin failures++; $display("FAIL reset_reg_write got=%b exp=0", saw_rw); end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset;
    test_lw;
    test_back_to_back;
    test_rtype;
    test_alu_decode;
    test_beq_j;
    test_addi;
    test_illegal;
    test_mem_lat2;
    test_reset_in_memrd;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
